alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Synthesizable initiator for the clocked 8-bit ALU. It replaces hand-driven stimulus with a small programmable instruction buffer. On start it issues each stored {A, B, opcode} triple to the ALU, waits the ALU latency, then captures and presents each result. An optional chain bit feeds the previous result back as operand A, so multi-step computations run autonomously.

Parameters:
W, 8, operand/result width (matches ALU A, B, out)
DEPTH, 16, instruction slots; power of two
ALU_LAT, 1, clock edges from ALU input change to valid alu_out; ≥1

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
prog_we  in  1  write instruction slot (IDLE only)
prog_addr  in  $clog2(DEPTH)  slot index for write
prog_data  in  1+4+2W  {chain, opcode, a, b}
start  in  1  begin run of len instructions from slot 0
len  in  $clog2(DEPTH)+1  instruction count, 1..DEPTH
busy  out  1  high from ISSUE of first instr through final CAPTURE
done  out  1  one-cycle pulse, coincides with last res_valid
err  out  1  one-cycle pulse on illegal request
alu_a  out  W  to ALU A (registered)
alu_b  out  W  to ALU B (registered)
alu_opcode  out  4  to ALU opcode (registered)
alu_out  in  W  from ALU out
res_valid  out  1  result present this cycle
res_data  out  W  captured result (= alu_out in CAPTURE)
res_idx  out  $clog2(DEPTH)  slot index of res_data

Behaviour:
- Reset (async, rst_n=0): state IDLE, ptr=0, last_res=0, alu_a/alu_b/alu_opcode=0, busy/done/err/res_valid=0, res_data/res_idx=0. Instruction memory is not cleared. Reset mid-run aborts immediately with no done pulse.
- FSM: IDLE -> ISSUE -> WAIT -> CAPTURE -> (ISSUE | IDLE).
- IDLE: start with 1≤len≤DEPTH: ptr←0, last_res←0, go ISSUE next cycle. Start with len=0 or len>DEPTH: stay IDLE, err pulse next cycle.
- ISSUE (1 cycle): register alu_opcode←mem[ptr].opcode, alu_b←mem[ptr].b, alu_a←(chain ? last_res : mem[ptr].a). Load wait counter with ALU_LAT-1. Go WAIT.
- WAIT (ALU_LAT cycles): decrement counter; at 0 go CAPTURE.
- CAPTURE (1 cycle): res_valid=1, res_data=alu_out, res_idx=ptr (Moore decode, combinational). last_res←alu_out.
  - If ptr==len-1: done=1 this cycle, then IDLE.
  - Otherwise ptr←ptr+1, then ISSUE.
- Latency: (2+ALU_LAT) cycles per instruction. With the start-accept cycle as cycle 0, done is high in cycle (2+ALU_LAT)·len.
- Memory write: prog_we in IDLE writes mem[prog_addr] at the edge. prog_we while busy is ignored and pulses err.
- Simultaneous events in IDLE:
  - start and prog_we in the same cycle: the write lands first; ISSUE sees the new contents.
  - start while busy: ignored, err pulse.
- Chain on instruction 0 uses last_res=0.
- Arithmetic: no width growth; all values are W bits, ALU wrap preserved. len is latched at start; later changes are ignored until IDLE.
- busy deasserts in the cycle after CAPTURE of the last instruction.

Decomposition:
- Package alu_pkg:
  - OPW=4
  - opcode constants OP_ADD=4'b0000, OP_SHL=4'b0110, OP_AND=4'b1000, OP_NOP=4'b1111
  - packed instr_t {chain, opcode, a, b}
  - seq_state_t enum {IDLE, ISSUE, WAIT, CAPTURE}
- Sub-module alu_prog_mem: DEPTH×instr_t register array, one synchronous write port, one asynchronous read port (ptr).

Test Plan:
1. Bench ALU model, OP_ADD=A+B mod 256, ALU_LAT=1. Program slot0={0,ADD,8'h04,8'h01}, start len=1. Expect alu_a=04, alu_b=01, opcode=0000 after ISSUE; res_valid with res_data=05, res_idx=0, done in cycle 3; busy low in cycle 4.
2. Chain: slot0={0,ADD,04,01}, slot1={1,ADD,8'hAA,03}, len=2. Expect results 05 (idx0, cycle 3), then 08 (idx1, cycle 6, done). The chained alu_a is 05, not AA.
3. Wrap: slot0={0,ADD,FF,02}. Expect res_data=01, no error.
4. Illegal: start with len=0, and separately len=17. Expect err pulse, busy stays 0. During a run, pulse start and prog_we: err pulse each time, memory unchanged, run results unchanged.
5. Reset mid-run: len=4, drop rst_n during WAIT of instr 1. Expect all outputs 0 asynchronously and no done. Restart len=1: slot0 result still correct, showing memory is retained.
6. ALU_LAT=3 build, len=2. Expect done in cycle 10; res_valid only in cycles 5 and 10.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequencer and its instruction store.
package alu_pkg;

    localparam int OPW = 4;
    localparam int DW  = 8;

    localparam logic [OPW-1:0] OP_ADD = 4'b0000;
    localparam logic [OPW-1:0] OP_SHL = 4'b0110;
    localparam logic [OPW-1:0] OP_AND = 4'b1000;
    localparam logic [OPW-1:0] OP_NOP = 4'b1111;

    // One stored instruction: chain selects the previous result as operand A.
    typedef struct packed {
        logic           chain;
        logic [OPW-1:0] opcode;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
    } instr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } seq_state_t;

endpackage

// File: rtl/alu_prog_mem.sv
// Instruction store: register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module alu_prog_mem
    import alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IW    = 1 + OPW + 2 * DW
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [IW-1:0]            wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [IW-1:0]            rdata_o
);

    logic [IW-1:0] mem_q [DEPTH];

    // Write the addressed slot on the rising edge when enabled.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Programmable initiator for a clocked ALU: issues stored {A, B, opcode}
// instructions, waits the ALU latency, and presents each captured result.
// Optional chaining feeds the previous result back in as operand A.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int DEPTH   = 16,
    parameter int ALU_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [OPW+2*W:0]         prog_data,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   len,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [W-1:0]             alu_a,
    output logic [W-1:0]             alu_b,
    output logic [OPW-1:0]           alu_opcode,
    input  logic [W-1:0]             alu_out,
    output logic                     res_valid,
    output logic [W-1:0]             res_data,
    output logic [$clog2(DEPTH)-1:0] res_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = 1 + OPW + 2 * W;
    localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    localparam logic [AW:0]   MAX_LEN  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LAT - 1);

    seq_state_t     state_q, state_d;
    logic [AW-1:0]  ptr_q;
    logic [AW:0]    len_q;
    logic [W-1:0]   last_res_q;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   alu_a_q, alu_b_q;
    logic [OPW-1:0] alu_op_q;
    logic           err_q, err_d;

    logic [IW-1:0]  instr;
    logic           instr_chain;
    logic [OPW-1:0] instr_op;
    logic [W-1:0]   instr_a, instr_b;
    logic           len_ok;
    logic           last_instr;
    logic           mem_we;

    // Writes are only honoured while idle, so a run never sees its program change.
    assign mem_we = prog_we && (state_q == IDLE);

    alu_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (ptr_q),
        .rdata_o (instr)
    );

    assign instr_chain = instr[IW-1];
    assign instr_op    = instr[IW-2 -: OPW];
    assign instr_a     = instr[2*W-1 -: W];
    assign instr_b     = instr[W-1:0];

    assign len_ok     = (len != '0) && (len <= MAX_LEN);
    assign last_instr = ({1'b0, ptr_q} == (len_q - LEN_ONE));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and illegal-request detection.
    always_comb begin
        state_d = state_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) state_d = ISSUE;
                    else        err_d   = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                err_d   = start || prog_we;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CAPTURE;
                err_d = start || prog_we;
            end
            CAPTURE: begin
                state_d = last_instr ? IDLE : ISSUE;
                err_d   = start || prog_we;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode; the result path is transparent from the ALU in CAPTURE.
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_idx   = '0;
        if (state_q != IDLE) busy = 1'b1;
        if (state_q == CAPTURE) begin
            res_valid = 1'b1;
            res_data  = alu_out;
            res_idx   = ptr_q;
            done      = last_instr;
        end
    end

    // Sequencing datapath: pointer, latched length, wait counter, ALU operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q      <= '0;
            len_q      <= '0;
            last_res_q <= '0;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_d;
            case (state_q)
                IDLE: begin
                    if (start && len_ok) begin
                        ptr_q      <= '0;
                        last_res_q <= '0;
                        len_q      <= len;
                    end
                end
                ISSUE: begin
                    alu_op_q <= instr_op;
                    alu_b_q  <= instr_b;
                    alu_a_q  <= instr_chain ? last_res_q : instr_a;
                    cnt_q    <= CNT_LOAD;
                end
                WAIT: begin
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_ONE;
                end
                CAPTURE: begin
                    last_res_q <= alu_out;
                    if (!last_instr) ptr_q <= ptr_q + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_opcode = alu_op_q;
    assign err        = err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: one instance with a 1-cycle ALU model and
// one with a 3-cycle ALU model, sharing the programming bus and reset.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n     = 1'b1;
    logic        prog_we   = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [20:0] prog_data = '0;
    logic        start     = 1'b0;
    logic        start3    = 1'b0;
    logic [4:0]  len       = '0;

    logic       busy1, done1, err1, rv1;
    logic [7:0] a1, b1, rd1;
    logic [3:0] op1, ri1;
    logic [7:0] alu1 = '0;

    logic       busy3, done3, err3, rv3;
    logic [7:0] a3, b3, rd3;
    logic [3:0] op3, ri3;
    logic [7:0] alu3 = '0, s0 = '0, s1 = '0;

    alu_sequencer #(.W(8), .DEPTH(16), .ALU_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start), .len(len), .busy(busy1),
        .done(done1), .err(err1), .alu_a(a1), .alu_b(b1), .alu_opcode(op1),
        .alu_out(alu1), .res_valid(rv1), .res_data(rd1), .res_idx(ri1)
    );

    alu_sequencer #(.W(8), .DEPTH(16), .ALU_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .start(start3), .len(len), .busy(busy3),
        .done(done3), .err(err3), .alu_a(a3), .alu_b(b3), .alu_opcode(op3),
        .alu_out(alu3), .res_valid(rv3), .res_data(rd3), .res_idx(ri3)
    );

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
        case (op)
            OP_ADD:  return a + b;
            OP_SHL:  return a << b[2:0];
            OP_AND:  return a & b;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) alu1 <= alu_f(a1, b1, op1);
    always @(posedge clk) begin
        s0   <= alu_f(a3, b3, op3);
        s1   <= s0;
        alu3 <= s1;
    end

    logic sel3 = 1'b0;
    wire       o_valid = sel3 ? rv3   : rv1;
    wire       o_done  = sel3 ? done3 : done1;
    wire       o_err   = sel3 ? err3  : err1;
    wire       o_busy  = sel3 ? busy3 : busy1;
    wire [7:0] o_data  = sel3 ? rd3   : rd1;
    wire [3:0] o_idx   = sel3 ? ri3   : ri1;
    wire [7:0] o_a     = sel3 ? a3    : a1;
    wire [7:0] o_b     = sel3 ? b3    : b1;
    wire [3:0] o_op    = sel3 ? op3   : op1;

    int checks = 0;
    int passed = 0;

    int         res_n, done_c, done_n, err_n, err_c, busy_n, busy_lo_c;
    logic [7:0] rdv [16];
    logic [7:0] rav [16];
    logic [7:0] rbv [16];
    logic [3:0] riv [16];
    logic [3:0] ropv[16];
    int         rcv [16];

    task automatic prog(input logic [3:0] addr, input logic ch, input logic [3:0] op,
                        input logic [7:0] a, input logic [7:0] b);
        instr_t ins;
        ins.chain  = ch;
        ins.opcode = op;
        ins.a      = a;
        ins.b      = b;
        prog_we    = 1'b1;
        prog_addr  = addr;
        prog_data  = ins;
        @(negedge clk);
        prog_we    = 1'b0;
    endtask

    // Starts a run in cycle 0 and records events for cycles 1..maxc.
    task automatic run(input bit use3, input logic [4:0] l, input int maxc,
                       input int inj_s, input int inj_w);
        sel3 = use3;
        res_n = 0; done_c = -1; done_n = 0; err_n = 0; err_c = -1;
        busy_n = 0; busy_lo_c = -1;
        len = l;
        if (use3) start3 = 1'b1;
        else      start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        start3 = 1'b0;
        for (int c = 1; c <= maxc; c++) begin
            if (o_valid && res_n < 16) begin
                rdv[res_n]  = o_data;
                riv[res_n]  = o_idx;
                rav[res_n]  = o_a;
                rbv[res_n]  = o_b;
                ropv[res_n] = o_op;
                rcv[res_n]  = c;
                res_n++;
            end
            if (o_done) begin done_n++; done_c = c; end
            if (o_err) begin err_n++; if (err_c < 0) err_c = c; end
            if (o_busy) busy_n++;
            else if (busy_lo_c < 0) busy_lo_c = c;
            start   = 1'b0;
            prog_we = 1'b0;
            if (c == inj_s) begin start = 1'b1; len = 5'd1; end
            if (c == inj_w) begin
                prog_we   = 1'b1;
                prog_addr = 4'd1;
                prog_data = 21'h1FFFFF;
            end
            @(negedge clk);
        end
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({busy1, done1, err1, rv1} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {busy1, done1, err1, rv1}); else passed++;
        checks++; if ({a1, b1, op1} !== 20'h0) $display("FAIL reset_alu_regs: got %h want 00000", {a1, b1, op1}); else passed++;
        checks++; if ({rd1, ri1} !== 12'h0) $display("FAIL reset_result: got %h want 000", {rd1, ri1}); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        prog(4'd0, 1'b0, OP_ADD, 8'h04, 8'h01);
        run(1'b0, 5'd1, 6, -1, -1);
        checks++; if (res_n !== 1) $display("FAIL single_count: got %0d want 1", res_n); else passed++;
        checks++; if (rdv[0] !== 8'h05) $display("FAIL single_data: got %h want 05", rdv[0]); else passed++;
        checks++; if (riv[0] !== 4'd0) $display("FAIL single_idx: got %0d want 0", riv[0]); else passed++;
        checks++; if ({rav[0], rbv[0], ropv[0]} !== {8'h04, 8'h01, OP_ADD}) $display("FAIL single_issue: got a=%h b=%h op=%b want a=04 b=01 op=0000", rav[0], rbv[0], ropv[0]); else passed++;
        checks++; if (rcv[0] !== 3) $display("FAIL single_res_cycle: got %0d want 3", rcv[0]); else passed++;
        checks++; if (done_c !== 3 || done_n !== 1) $display("FAIL single_done: got cycle %0d count %0d want cycle 3 count 1", done_c, done_n); else passed++;
        checks++; if (busy_lo_c !== 4 || busy_n !== 3) $display("FAIL single_busy: got low at %0d high %0d cycles want low at 4 high 3", busy_lo_c, busy_n); else passed++;
    endtask

    task automatic test_chain;
        prog(4'd1, 1'b1, OP_ADD, 8'hAA, 8'h03);
        run(1'b0, 5'd2, 9, -1, -1);
        checks++; if (res_n !== 2) $display("FAIL chain_count: got %0d want 2", res_n); else passed++;
        checks++; if (rdv[0] !== 8'h05 || rcv[0] !== 3 || riv[0] !== 4'd0) $display("FAIL chain_first: got %h@%0d idx %0d want 05@3 idx 0", rdv[0], rcv[0], riv[0]); else passed++;
        checks++; if (rdv[1] !== 8'h08 || rcv[1] !== 6 || riv[1] !== 4'd1) $display("FAIL chain_second: got %h@%0d idx %0d want 08@6 idx 1", rdv[1], rcv[1], riv[1]); else passed++;
        checks++; if (rav[1] !== 8'h05) $display("FAIL chain_operand: got %h want 05", rav[1]); else passed++;
        checks++; if (done_c !== 6 || done_n !== 1) $display("FAIL chain_done: got cycle %0d count %0d want cycle 6 count 1", done_c, done_n); else passed++;
    endtask

    task automatic test_wrap;
        prog(4'd0, 1'b0, OP_ADD, 8'hFF, 8'h02);
        run(1'b0, 5'd1, 5, -1, -1);
        checks++; if (rdv[0] !== 8'h01 || res_n !== 1) $display("FAIL wrap_data: got %h (n=%0d) want 01 (n=1)", rdv[0], res_n); else passed++;
        checks++; if (err_n !== 0) $display("FAIL wrap_err: got %0d pulses want 0", err_n); else passed++;
    endtask

    task automatic test_illegal;
        prog(4'd0, 1'b0, OP_ADD, 8'h04, 8'h01);
        run(1'b0, 5'd0, 3, -1, -1);
        checks++; if (err_n !== 1 || err_c !== 1) $display("FAIL illegal_len0_err: got %0d pulses first %0d want 1 at 1", err_n, err_c); else passed++;
        checks++; if (busy_n !== 0 || res_n !== 0) $display("FAIL illegal_len0_busy: got busy %0d res %0d want 0 0", busy_n, res_n); else passed++;
        run(1'b0, 5'd17, 3, -1, -1);
        checks++; if (err_n !== 1 || err_c !== 1) $display("FAIL illegal_len17_err: got %0d pulses first %0d want 1 at 1", err_n, err_c); else passed++;
        checks++; if (busy_n !== 0 || res_n !== 0) $display("FAIL illegal_len17_busy: got busy %0d res %0d want 0 0", busy_n, res_n); else passed++;
        run(1'b0, 5'd2, 9, 2, 4);
        checks++; if (err_n !== 2 || err_c !== 3) $display("FAIL busy_req_err: got %0d pulses first %0d want 2 at 3", err_n, err_c); else passed++;
        checks++; if (res_n !== 2 || rdv[0] !== 8'h05 || rdv[1] !== 8'h08 || done_c !== 6) $display("FAIL busy_req_results: got n=%0d %h %h done %0d want n=2 05 08 done 6", res_n, rdv[0], rdv[1], done_c); else passed++;
        run(1'b0, 5'd2, 9, -1, -1);
        checks++; if (res_n !== 2 || rdv[1] !== 8'h08) $display("FAIL busy_write_ignored: got n=%0d %h want n=2 08", res_n, rdv[1]); else passed++;
    endtask

    task automatic test_reset_mid;
        int dn;
        int bz;
        dn = 0;
        bz = 0;
        sel3 = 1'b0;
        len  = 5'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 5; c++) begin
            if (done1) dn++;
            @(negedge clk);
        end
        checks++; if (busy1 !== 1'b1 || a1 !== 8'h05) $display("FAIL midrun_before: got busy %b a %h want 1 05", busy1, a1); else passed++;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy1, done1, err1, rv1} !== 4'b0) $display("FAIL midrun_async_ctrl: got %b want 0000", {busy1, done1, err1, rv1}); else passed++;
        checks++; if ({a1, b1, op1, rd1, ri1} !== 32'h0) $display("FAIL midrun_async_data: got %h want 00000000", {a1, b1, op1, rd1, ri1}); else passed++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (done1) dn++;
            if (busy1) bz++;
            @(negedge clk);
        end
        checks++; if (dn !== 0 || bz !== 0) $display("FAIL midrun_no_done: got done %0d busy %0d want 0 0", dn, bz); else passed++;
        run(1'b0, 5'd1, 5, -1, -1);
        checks++; if (res_n !== 1 || rdv[0] !== 8'h05) $display("FAIL midrun_mem_kept: got n=%0d %h want n=1 05", res_n, rdv[0]); else passed++;
    endtask

    task automatic test_lat3;
        prog(4'd0, 1'b0, OP_ADD, 8'h04, 8'h01);
        prog(4'd1, 1'b1, OP_ADD, 8'hAA, 8'h03);
        run(1'b1, 5'd2, 13, -1, -1);
        checks++; if (res_n !== 2) $display("FAIL lat3_count: got %0d want 2", res_n); else passed++;
        checks++; if (rcv[0] !== 5 || rcv[1] !== 10) $display("FAIL lat3_cycles: got %0d %0d want 5 10", rcv[0], rcv[1]); else passed++;
        checks++; if (rdv[0] !== 8'h05 || rdv[1] !== 8'h08) $display("FAIL lat3_data: got %h %h want 05 08", rdv[0], rdv[1]); else passed++;
        checks++; if (done_c !== 10 || done_n !== 1) $display("FAIL lat3_done: got cycle %0d count %0d want 10 1", done_c, done_n); else passed++;
        sel3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_chain;
        test_wrap;
        test_illegal;
        test_reset_mid;
        test_lat3;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
